// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and helpers for the single-issue ALU/regfile sequencer.
// Opcode and ALU select encodings, FSM states and instruction field positions.
package alu_seq_pkg;

  localparam int DATA_W  = 4;
  localparam int IDX_W   = 4;
  localparam int OP_W    = 3;
  localparam int INSTR_W = 15;

  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_MOVI = 3'b100;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [OP_W-1:0] opField(input logic [INSTR_W-1:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] rdField(input logic [INSTR_W-1:0] ins);
    return ins[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] rs1Field(input logic [INSTR_W-1:0] ins);
    return ins[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] rs2Field(input logic [INSTR_W-1:0] ins);
    return ins[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of instruction handshake, regfile and ALU connections for the sequencer.
// master = the sequencer itself, slave = instruction source plus regfile/ALU side.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [IDX_W-1:0]   rf_rr1;
  logic [IDX_W-1:0]   rf_rr2;
  logic [IDX_W-1:0]   rf_wr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               rf_wenable;
  logic [DATA_W-1:0]  rf_rdata1;
  logic [DATA_W-1:0]  rf_rdata2;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [1:0]         alu_select;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_cf;
  logic               alu_zf;
  logic               alu_sf;
  logic               done;
  logic [DATA_W-1:0]  result;
  logic               flag_cf;
  logic               flag_zf;
  logic               flag_sf;
  logic               invalid;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_res, alu_cf, alu_zf, alu_sf,
    output instr_ready, rf_rr1, rf_rr2, rf_wr, rf_wdata, rf_wenable,
           alu_a, alu_b, alu_select, done, result, flag_cf, flag_zf, flag_sf, invalid
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_res, alu_cf, alu_zf, alu_sf,
    input  instr_ready, rf_rr1, rf_rr2, rf_wr, rf_wdata, rf_wenable,
           alu_a, alu_b, alu_select, done, result, flag_cf, flag_zf, flag_sf, invalid
  );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode decoder: ALU function select and instruction class.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output logic [1:0]      o_alu_select,
  output logic            o_is_alu,
  output logic            o_is_movi,
  output logic            o_is_invalid
);

  always_comb begin
    o_alu_select = SEL_ADD;
    o_is_alu     = 1'b0;
    o_is_movi    = 1'b0;
    o_is_invalid = 1'b0;
    case (i_opcode)
      OP_AND:  begin o_alu_select = SEL_AND; o_is_alu = 1'b1; end
      OP_OR:   begin o_alu_select = SEL_OR;  o_is_alu = 1'b1; end
      OP_ADD:  begin o_alu_select = SEL_ADD; o_is_alu = 1'b1; end
      OP_SUB:  begin o_alu_select = SEL_SUB; o_is_alu = 1'b1; end
      OP_MOVI: o_is_movi = 1'b1;
      default: o_is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-instruction-at-a-time controller: read regfile, run ALU, write back, pulse done.
// All outputs are decoded from the current state, so a reset clears them immediately.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_op_sequencer_if.master bus
);

  state_e             r_state;
  state_e             w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_result;
  logic               r_cf;
  logic               r_zf;
  logic               r_sf;

  logic [OP_W-1:0]    w_opcode;
  logic [1:0]         w_aluSel;
  logic               w_isAlu;
  logic               w_isMovi;
  logic               w_isInvalid;
  logic               w_idle;
  logic               w_accept;
  logic [DATA_W-1:0]  w_wbData;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && bus.instr_valid;

  // While idle the decoder looks at the offered instruction to pick the first state;
  // afterwards it looks at the latched copy.
  assign w_opcode = w_idle ? opField(bus.instr) : opField(r_instr);
  assign w_wbData = w_isMovi ? rs2Field(r_instr) : bus.alu_res;

  alu_seq_decode u_decode (
    .i_opcode     (w_opcode),
    .o_alu_select (w_aluSel),
    .o_is_alu     (w_isAlu),
    .o_is_movi    (w_isMovi),
    .o_is_invalid (w_isInvalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_isAlu)       w_next = S_RD;
          else if (w_isMovi) w_next = S_WB;
          else               w_next = S_DONE;
        end
      end
      S_RD:    w_next = S_EX;
      S_EX:    w_next = S_WB;
      S_WB:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rf_rr1     = '0;
    bus.rf_rr2     = '0;
    bus.rf_wr      = '0;
    bus.rf_wdata   = '0;
    bus.rf_wenable = 1'b0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_select = SEL_ADD;
    bus.done       = 1'b0;
    bus.invalid    = 1'b0;
    case (r_state)
      S_RD: begin
        bus.rf_rr1 = rs1Field(r_instr);
        bus.rf_rr2 = rs2Field(r_instr);
      end
      S_EX: begin
        bus.alu_a      = bus.rf_rdata1;
        bus.alu_b      = bus.rf_rdata2;
        bus.alu_select = w_aluSel;
      end
      S_WB: begin
        bus.rf_wenable = 1'b1;
        bus.rf_wr      = rdField(r_instr);
        bus.rf_wdata   = w_wbData;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.invalid = w_isInvalid;
      end
      default: ;
    endcase
  end

  // Flags only move on ALU writebacks; MOVI updates result alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_result <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
    end else begin
      if (w_accept) r_instr <= bus.instr;
      if (r_state == S_WB) begin
        r_result <= w_wbData;
        if (w_isAlu) begin
          r_cf <= bus.alu_cf;
          r_zf <= bus.alu_zf;
          r_sf <= bus.alu_sf;
        end
      end
    end
  end

  assign bus.instr_ready = w_idle && rst_n;
  assign bus.result      = r_result;
  assign bus.flag_cf     = r_cf;
  assign bus.flag_zf     = r_zf;
  assign bus.flag_sf     = r_sf;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural regfile and ALU around it.
// Directed table first, then corner sequences, then random instructions against a model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if sif ();

  alu_op_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  typedef struct packed {
    logic [3:0] res;
    logic       cf;
    logic       zf;
    logic       sf;
  } alu_out_t;

  typedef struct {
    logic [14:0] ins;
    int          lat;
    logic        wen;
    logic [3:0]  wr;
    logic [3:0]  wdata;
    logic [3:0]  result;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        inv;
    logic        isAlu;
    logic [1:0]  sel;
    logic [3:0]  a;
    logic [3:0]  b;
  } vec_t;

  // Stand-in ALU: cf marks a sum that leaves the signed range, SUB yields magnitude plus sf.
  function automatic alu_out_t aluCalc(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    alu_out_t o;
    int       sum;
    o   = '0;
    sum = int'(a) + int'(b);
    case (sel)
      2'b00: begin o.res = 4'(sum); o.cf = (sum > 7); end
      2'b01: begin
        if (a >= b) o.res = a - b;
        else begin o.res = b - a; o.sf = 1'b1; end
      end
      2'b10:   o.res = a & b;
      default: o.res = a | b;
    endcase
    o.zf = (o.res == 4'd0);
    return o;
  endfunction

  logic [3:0] rfMem [16] = '{default: 4'd0};
  logic [3:0] rdA = 4'd0;
  logic [3:0] rdB = 4'd0;
  alu_out_t   aluQ = '0;

  always @(posedge clk) begin
    rdA <= rfMem[sif.rf_rr1];
    rdB <= rfMem[sif.rf_rr2];
    if (sif.rf_wenable) rfMem[sif.rf_wr] <= sif.rf_wdata;
    aluQ <= aluCalc(sif.alu_select, sif.alu_a, sif.alu_b);
  end

  assign sif.rf_rdata1 = rdA;
  assign sif.rf_rdata2 = rdB;
  assign sif.alu_res   = aluQ.res;
  assign sif.alu_cf    = aluQ.cf;
  assign sif.alu_zf    = aluQ.zf;
  assign sif.alu_sf    = aluQ.sf;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [3:0] refRf [16] = '{default: 4'd0};
  logic [3:0] mResult = 4'd0;
  logic       mCf = 1'b0;
  logic       mZf = 1'b0;
  logic       mSf = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t refPredict(input logic [14:0] ins);
    vec_t       v;
    alu_out_t   ao;
    logic [2:0] op;
    op = ins[14:12];
    v.ins = ins; v.lat = 1; v.wen = 1'b0; v.wr = 4'd0; v.wdata = 4'd0;
    v.result = mResult; v.cf = mCf; v.zf = mZf; v.sf = mSf;
    v.inv = 1'b0; v.isAlu = 1'b0; v.sel = 2'b00; v.a = 4'd0; v.b = 4'd0;
    if (op <= 3'd3) begin
      case (op)
        3'd0:    v.sel = 2'b10;
        3'd1:    v.sel = 2'b11;
        3'd2:    v.sel = 2'b00;
        default: v.sel = 2'b01;
      endcase
      v.isAlu = 1'b1;
      v.a = refRf[ins[7:4]];
      v.b = refRf[ins[3:0]];
      ao = aluCalc(v.sel, v.a, v.b);
      v.lat = 4; v.wen = 1'b1; v.wr = ins[11:8]; v.wdata = ao.res;
      v.result = ao.res; v.cf = ao.cf; v.zf = ao.zf; v.sf = ao.sf;
    end else if (op == 3'd4) begin
      v.lat = 2; v.wen = 1'b1; v.wr = ins[11:8]; v.wdata = ins[3:0]; v.result = ins[3:0];
    end else begin
      v.inv = 1'b1;
    end
    return v;
  endfunction

  task automatic refCommit(input vec_t v);
    if (v.wen) refRf[v.wr] = v.wdata;
    mResult = v.result; mCf = v.cf; mZf = v.zf; mSf = v.sf;
  endtask

  // Starts and ends at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic applyStimulus(input logic [14:0] ins, input vec_t exp);
    int         guard, doneAt, wCnt, wrAt, badIdle;
    logic [3:0] gWr, gWd, gRr1, gRr2, gA, gB;
    logic [1:0] gSel;
    logic       gInv;
    guard = 0;
    while (!sif.instr_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    checkOutput("readyBeforeIssue", 32'(sif.instr_ready), 32'd1);
    sif.instr = ins;
    sif.instr_valid = 1'b1;
    @(posedge clk); #1;
    sif.instr_valid = 1'b0;
    sif.instr = 15'($urandom);
    doneAt = 0; wCnt = 0; wrAt = 0; badIdle = 0;
    gWr = 0; gWd = 0; gRr1 = 0; gRr2 = 0; gA = 0; gB = 0; gSel = 0; gInv = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin gRr1 = sif.rf_rr1; gRr2 = sif.rf_rr2; end
      if (c == 2) begin gSel = sif.alu_select; gA = sif.alu_a; gB = sif.alu_b; end
      if (sif.rf_wenable) begin wCnt++; wrAt = c; gWr = sif.rf_wr; gWd = sif.rf_wdata; end
      else if (sif.rf_wr != 4'd0 || sif.rf_wdata != 4'd0) badIdle++;
      if (sif.done) begin doneAt = c; gInv = sif.invalid; break; end
      @(posedge clk); #1;
    end
    checkOutput("doneLatency", 32'(doneAt), 32'(exp.lat));
    if (doneAt == 0) begin
      guard = 0;
      while (!sif.instr_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    end
    @(posedge clk); #1;
    checkOutput("readyAfterDone", 32'(sif.instr_ready), 32'd1);
    checkOutput("invalid", 32'(gInv), 32'(exp.inv));
    checkOutput("writeCount", 32'(wCnt), exp.wen ? 32'd1 : 32'd0);
    checkOutput("nonWbWriteBusZero", 32'(badIdle), 32'd0);
    if (exp.wen) begin
      checkOutput("rf_wr", 32'(gWr), 32'(exp.wr));
      checkOutput("rf_wdata", 32'(gWd), 32'(exp.wdata));
      checkOutput("writeCycle", 32'(wrAt), 32'(exp.lat - 1));
      checkOutput("regfileContent", 32'(rfMem[exp.wr]), 32'(exp.wdata));
    end
    checkOutput("result", 32'(sif.result), 32'(exp.result));
    checkOutput("flags", {29'd0, sif.flag_cf, sif.flag_zf, sif.flag_sf}, {29'd0, exp.cf, exp.zf, exp.sf});
    if (exp.isAlu) begin
      checkOutput("rf_rr1", 32'(gRr1), 32'(ins[7:4]));
      checkOutput("rf_rr2", 32'(gRr2), 32'(ins[3:0]));
      checkOutput("alu_select", 32'(gSel), 32'(exp.sel));
      checkOutput("alu_a", 32'(gA), 32'(exp.a));
      checkOutput("alu_b", 32'(gB), 32'(exp.b));
    end
  endtask

  vec_t        tbl [9];
  vec_t        p;
  logic [14:0] ins;
  logic [5:0]  wenMask, doneMask, rdyMask;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ins, lat, wen, wr, wdata, result, cf, zf, sf, inv, isAlu, sel, a, b
    tbl[0] = '{{3'b100, 4'd1, 4'd0, 4'd5},  2, 1'b1, 4'd1, 4'd5,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0};
    tbl[1] = '{{3'b100, 4'd2, 4'd0, 4'd3},  2, 1'b1, 4'd2, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0};
    tbl[2] = '{{3'b010, 4'd3, 4'd1, 4'd2},  4, 1'b1, 4'd3, 4'd8,  4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd5, 4'd3};
    tbl[3] = '{{3'b011, 4'd4, 4'd2, 4'd1},  4, 1'b1, 4'd4, 4'd2,  4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'd3, 4'd5};
    tbl[4] = '{{3'b011, 4'd6, 4'd1, 4'd1},  4, 1'b1, 4'd6, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 4'd5, 4'd5};
    tbl[5] = '{{3'b100, 4'd8, 4'd0, 4'd10}, 2, 1'b1, 4'd8, 4'd10, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0};
    tbl[6] = '{{3'b111, 4'd9, 4'd1, 4'd2},  1, 1'b0, 4'd0, 4'd0,  4'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0};
    tbl[7] = '{{3'b000, 4'd5, 4'd1, 4'd2},  4, 1'b1, 4'd5, 4'd1,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd5, 4'd3};
    tbl[8] = '{{3'b001, 4'd7, 4'd1, 4'd2},  4, 1'b1, 4'd7, 4'd7,  4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'd5, 4'd3};

    rst_n = 1'b0;
    sif.instr_valid = 1'b0;
    sif.instr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetStrobes", {28'd0, sif.done, sif.rf_wenable, sif.invalid, 1'b0}, 32'd0);
    checkOutput("resetResult", 32'(sif.result), 32'd0);
    checkOutput("resetFlags", {29'd0, sif.flag_cf, sif.flag_zf, sif.flag_sf}, 32'd0);
    checkOutput("resetRfBus", {16'd0, sif.rf_rr1, sif.rf_rr2, sif.rf_wr, sif.rf_wdata}, 32'd0);
    checkOutput("resetAluBus", {22'd0, sif.alu_a, sif.alu_b, sif.alu_select}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("readyAfterReset", 32'(sif.instr_ready), 32'd1);

    $display("[TB] directed table");
    for (int i = 0; i < 9; i++) begin
      p = refPredict(tbl[i].ins);
      applyStimulus(tbl[i].ins, tbl[i]);
      refCommit(p);
    end

    $display("[TB] valid held high across two MOVIs");
    ins = {3'b100, 4'd13, 4'd0, 4'd6};
    p = refPredict(ins);
    sif.instr = ins;
    sif.instr_valid = 1'b1;
    @(posedge clk); #1;
    wenMask = '0; doneMask = '0; rdyMask = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) sif.instr_valid = 1'b0;
      wenMask[c-1]  = sif.rf_wenable;
      doneMask[c-1] = sif.done;
      rdyMask[c-1]  = sif.instr_ready;
      if (c < 6) begin @(posedge clk); #1; end
    end
    checkOutput("heldValidWenable", 32'(wenMask), 32'(6'b001001));
    checkOutput("heldValidDone", 32'(doneMask), 32'(6'b010010));
    checkOutput("heldValidReady", 32'(rdyMask), 32'(6'b100100));
    refCommit(p);
    refCommit(p);
    checkOutput("heldValidResult", 32'(sif.result), 32'(mResult));
    checkOutput("heldValidRegfile", 32'(rfMem[13]), 32'(refRf[13]));

    $display("[TB] reset during EX of an ADD");
    ins = {3'b100, 4'd11, 4'd0, 4'd0};
    p = refPredict(ins);
    applyStimulus(ins, p);
    refCommit(p);
    ins = {3'b010, 4'd11, 4'd1, 4'd2};
    sif.instr = ins;
    sif.instr_valid = 1'b1;
    @(posedge clk); #1;
    sif.instr_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("preAbortAluA", 32'(sif.alu_a), 32'(refRf[1]));
    rst_n = 1'b0;
    #1;
    checkOutput("abortStrobes", {28'd0, sif.done, sif.rf_wenable, sif.invalid, sif.instr_ready}, 32'd0);
    checkOutput("abortResultFlags", {25'd0, sif.result, sif.flag_cf, sif.flag_zf, sif.flag_sf}, 32'd0);
    checkOutput("abortRfBus", {16'd0, sif.rf_rr1, sif.rf_rr2, sif.rf_wr, sif.rf_wdata}, 32'd0);
    checkOutput("abortAluBus", {22'd0, sif.alu_a, sif.alu_b, sif.alu_select}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abortNoWrite", 32'(rfMem[11]), 32'(refRf[11]));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("readyAfterAbort", 32'(sif.instr_ready), 32'd1);
    mResult = 4'd0; mCf = 1'b0; mZf = 1'b0; mSf = 1'b0;
    ins = {3'b100, 4'd12, 4'd0, 4'd9};
    p = refPredict(ins);
    applyStimulus(ins, p);
    refCommit(p);
    checkOutput("abortRegfileKept", 32'(rfMem[11]), 32'(refRf[11]));

    $display("[TB] random instructions");
    for (int n = 0; n < 60; n++) begin
      ins = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      p = refPredict(ins);
      applyStimulus(ins, p);
      refCommit(p);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int r = 0; r < 16; r++) checkOutput("finalRegfile", 32'(rfMem[r]), 32'(refRf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
